mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 171 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Byte-wide bus master: fetches 4-byte instructions, then does an optional byte/word load or store.
// Defining MEMU_BUS_TIMEOUT_EN adds a 256-cycle ack watchdog that parks the unit in HALT with bus_fault set.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] PC,
    input  logic [7:0]  CS,
    input  logic [7:0]  DS,
    input  logic [7:0]  SS,
    input  logic [15:0] ACC,
    input  logic [15:0] V2,
    input  logic        ld_req,
    input  logic        st_req,
    input  logic        use_ss,
    input  logic        wb,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [15:0] mem_data,
    output logic        execution_signal,
    output logic        busy,
    output logic [23:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_we,
    output logic        bus_req,
    input  logic        bus_ack,
    input  logic [7:0]  bus_rdata,
    output logic        bus_fault
);

    typedef enum logic [2:0] {FETCH, ISSUE, DATA, EXEC, HALT} state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] instr_q, instr_d;
    logic [15:0] mem_q, mem_d;
    logic        store_q, store_d;
    logic        byte_q, byte_d;
    logic        use_ss_q, use_ss_d;
    logic        xfer;
    logic        last_data;
    logic        timeout;

    assign xfer      = bus_req & bus_ack;
    assign last_data = byte_q ? (cnt_q == 2'd0) : (cnt_q == 2'd1);

`ifdef MEMU_BUS_TIMEOUT_EN
    logic [7:0] wait_q, wait_d;

    // Counts consecutive unacknowledged request cycles; any ack or idle cycle restarts it.
    assign wait_d  = (bus_req && !bus_ack) ? wait_q + 8'd1 : 8'd0;
    assign timeout = bus_req && !bus_ack && (wait_q == 8'hFF);

    always_ff @(posedge clk) begin
        if (!rst) wait_q <= 8'd0;
        else      wait_q <= wait_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= FETCH;
            cnt_q    <= 2'd0;
            instr_q  <= 32'h0;
            mem_q    <= 16'h0;
            store_q  <= 1'b0;
            byte_q   <= 1'b0;
            use_ss_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            instr_q  <= instr_d;
            mem_q    <= mem_d;
            store_q  <= store_d;
            byte_q   <= byte_d;
            use_ss_q <= use_ss_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        instr_d  = instr_q;
        mem_d    = mem_q;
        store_d  = store_q;
        byte_d   = byte_q;
        use_ss_d = use_ss_q;
        case (state_q)
            FETCH: begin
                if (timeout) begin
                    state_d = HALT;
                end else if (xfer) begin
                    instr_d[{cnt_q, 3'b000} +: 8] = bus_rdata;
                    if (cnt_q == 2'd3) begin
                        state_d = ISSUE;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            // Decoder qualifiers are latched here only; a load wins over a store.
            ISSUE: begin
                store_d  = !ld_req && st_req;
                byte_d   = wb;
                use_ss_d = use_ss;
                cnt_d    = 2'd0;
                state_d  = (ld_req || st_req) ? DATA : EXEC;
            end
            DATA: begin
                if (timeout) begin
                    state_d = HALT;
                end else if (xfer) begin
                    if (!store_q) begin
                        if (byte_q) mem_d = {8'h00, bus_rdata};
                        else        mem_d[{cnt_q[0], 3'b000} +: 8] = bus_rdata;
                    end
                    if (last_data) begin
                        state_d = EXEC;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            EXEC:    state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // Bus strobes are masked by rst so nothing is requested while reset is held.
    always_comb begin
        bus_req          = 1'b0;
        bus_we           = 1'b0;
        bus_wdata        = 8'h00;
        bus_addr         = 24'h0;
        busy             = 1'b0;
        instr_valid      = 1'b0;
        execution_signal = 1'b0;
        bus_fault        = 1'b0;
        case (state_q)
            FETCH: begin
                bus_req  = rst;
                bus_addr = {CS, PC + {14'd0, cnt_q}};
                busy     = 1'b1;
            end
            ISSUE: instr_valid = 1'b1;
            DATA: begin
                bus_req   = rst;
                bus_addr  = {(use_ss_q ? SS : DS), ACC + {14'd0, cnt_q}};
                bus_we    = store_q & rst;
                bus_wdata = (store_q && rst) ? (cnt_q[0] ? V2[15:8] : V2[7:0]) : 8'h00;
                busy      = 1'b1;
            end
            EXEC: execution_signal = 1'b1;
            HALT: begin
                busy = 1'b1;
`ifdef MEMU_BUS_TIMEOUT_EN
                bus_fault = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    assign instr    = instr_q;
    assign mem_data = mem_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed and randomized instructions against a transaction-level model.
// Exercises the watchdog when MEMU_BUS_TIMEOUT_EN is defined, otherwise checks that the unit waits forever.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] PC = 16'h0;
    logic [7:0]  CS = 8'h0, DS = 8'h0, SS = 8'h0;
    logic [15:0] ACC = 16'h0, V2 = 16'h0;
    logic        ld_req = 1'b0, st_req = 1'b0, use_ss = 1'b0, wb = 1'b0;
    logic [31:0] instr;
    logic        instr_valid, execution_signal, busy;
    logic [15:0] mem_data;
    logic [23:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_we, bus_req, bus_fault;
    logic        bus_ack = 1'b0;
    logic [7:0]  bus_rdata = 8'h0;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .PC(PC), .CS(CS), .DS(DS), .SS(SS), .ACC(ACC), .V2(V2),
        .ld_req(ld_req), .st_req(st_req), .use_ss(use_ss), .wb(wb),
        .instr(instr), .instr_valid(instr_valid), .mem_data(mem_data),
        .execution_signal(execution_signal), .busy(busy),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_req(bus_req),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_fault(bus_fault)
    );

    always #5 clk = ~clk;

    int testsRun = 0;
    int testsFailed = 0;

    // Responder configuration and intended decoder outputs for the ISSUE cycle
    int  ackDelay = 0;
    bit  ackAlways = 0, ackNever = 0;
    bit  planLd, planSt, planSs, planWb;

    // Observations gathered once per cycle
    int          cycle, ivCount, esCount, ivCycle, esCycle, stabErr, faultTick, waitCnt;
    logic [31:0] capInstr;
    logic [15:0] capMem;
    logic [1:0]  capIvBusyReq, capEsBusyReq;
    logic        firstReq, sawWe, stalled;
    logic [23:0] firstAddr, heldAddr;
    logic        heldWe;
    logic [7:0]  heldWdata;
    logic [32:0] txnQ[$];
    logic [7:0]  memOvr [int];
    logic [15:0] expMem = 16'h0;

    function automatic logic [7:0] memByte(input logic [23:0] a);
        if (memOvr.exists(int'(a))) return memOvr[int'(a)];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    task automatic checkOutput(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, observe, then act as the bus slave.
    task automatic applyStimulus(input logic rstVal);
        @(negedge clk);
        rst = rstVal;
        #1;
        cycle++;
        if (cycle == 1) begin
            firstReq  = bus_req;
            firstAddr = bus_addr;
        end
        if (instr_valid) begin
            ivCount++;
            ivCycle      = cycle;
            capInstr     = instr;
            capIvBusyReq = {busy, bus_req};
        end
        if (execution_signal) begin
            esCount++;
            esCycle      = cycle;
            capMem       = mem_data;
            capEsBusyReq = {busy, bus_req};
        end
        if (bus_fault && faultTick == 0) faultTick = cycle;
        if (bus_we) sawWe = 1'b1;
        if (instr_valid) begin
            ld_req = planLd; st_req = planSt; use_ss = planSs; wb = planWb;
        end else begin
            {ld_req, st_req, use_ss, wb} = 4'($urandom);
        end
        if (bus_req) begin
            if (stalled && (bus_addr !== heldAddr || bus_we !== heldWe || bus_wdata !== heldWdata))
                stabErr++;
            if (!ackNever && waitCnt >= ackDelay) begin
                bus_ack   = 1'b1;
                bus_rdata = memByte(bus_addr);
                txnQ.push_back({bus_addr, bus_we, bus_we ? bus_wdata : 8'h00});
                waitCnt   = 0;
                stalled   = 1'b0;
            end else begin
                bus_ack   = 1'b0;
                bus_rdata = 8'($urandom);
                waitCnt++;
                stalled   = 1'b1;
                heldAddr  = bus_addr;
                heldWe    = bus_we;
                heldWdata = bus_wdata;
            end
        end else begin
            bus_ack   = ackNever ? 1'b0 : (ackAlways ? 1'b1 : 1'($urandom));
            bus_rdata = 8'($urandom);
            waitCnt   = 0;
            stalled   = 1'b0;
        end
    endtask

    task automatic clearObs();
        cycle = 0; ivCount = 0; esCount = 0; ivCycle = 0; esCycle = 0;
        stabErr = 0; faultTick = 0; waitCnt = 0; stalled = 1'b0; sawWe = 1'b0;
        txnQ.delete();
    endtask

    task automatic resetDut();
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        checkOutput("rst instr", instr, 32'h0);
        checkOutput("rst mem_data", mem_data, 16'h0);
        checkOutput("rst strobes", {instr_valid, execution_signal, bus_req, bus_we, bus_fault}, 5'b0);
        checkOutput("rst wdata", bus_wdata, 8'h0);
        expMem = 16'h0;
        clearObs();
    endtask

    // Runs one instruction from FETCH to EXEC and compares against the transaction-level model.
    task automatic runInstr(input string name, input bit ld, input bit st, input bit ss,
                            input bit wbv, input int delay);
        logic [32:0] expQ[$];
        logic [31:0] expInstr;
        logic [23:0] a;
        logic [7:0]  b [2];
        logic [7:0]  seg;
        int          n;
        bit          isStore;
        planLd = ld; planSt = st; planSs = ss; planWb = wbv;
        ackDelay = delay;
        expInstr = 32'h0;
        for (int k = 0; k < 4; k++) begin
            a = {CS, PC + 16'(k)};
            expQ.push_back({a, 1'b0, 8'h00});
            expInstr[8*k +: 8] = memByte(a);
        end
        n       = (ld || st) ? (wbv ? 1 : 2) : 0;
        isStore = !ld && st;
        seg     = ss ? SS : DS;
        b[0] = 8'h0; b[1] = 8'h0;
        for (int k = 0; k < n; k++) begin
            a = {seg, ACC + 16'(k)};
            if (isStore) expQ.push_back({a, 1'b1, V2[8*k +: 8]});
            else         expQ.push_back({a, 1'b0, 8'h00});
            b[k] = memByte(a);
        end
        if (ld) expMem = wbv ? {8'h00, b[0]} : {b[1], b[0]};
        clearObs();
        for (int t = 0; t < 400 && esCount == 0; t++) applyStimulus(1'b1);
        checkOutput({name, " exec seen"}, 48'(esCount), 48'd1);
        checkOutput({name, " txn count"}, 48'(txnQ.size()), 48'(expQ.size()));
        for (int i = 0; i < expQ.size(); i++)
            if (i < txnQ.size()) checkOutput($sformatf("%s txn%0d", name, i), txnQ[i], expQ[i]);
        checkOutput({name, " instr"}, capInstr, expInstr);
        checkOutput({name, " instr_valid pulses"}, 48'(ivCount), 48'd1);
        checkOutput({name, " mem_data"}, capMem, expMem);
        checkOutput({name, " held while waiting"}, 48'(stabErr), 48'd0);
        checkOutput({name, " busy/req in ISSUE,EXEC"}, {capIvBusyReq, capEsBusyReq}, 4'b0000);
        if (delay == 0) begin
            checkOutput({name, " issue cycle"}, 48'(ivCycle), 48'd5);
            checkOutput({name, " exec cycle"}, 48'(esCycle), 48'(6 + n));
        end
    endtask

    initial begin
        clearObs();
        CS = 8'hFF; PC = 16'h0000;
        memOvr[int'(24'hFF0000)] = 8'h11;
        memOvr[int'(24'hFF0001)] = 8'h22;
        memOvr[int'(24'hFF0002)] = 8'h33;
        memOvr[int'(24'hFF0003)] = 8'h44;
        resetDut();
        ackAlways = 1;
        runInstr("fetch FF0000", 0, 0, 0, 0, 0);
        checkOutput("fetch FF0000 literal instr", capInstr, 32'h44332211);
        ackAlways = 0;

        CS = 8'h01; PC = 16'hFFFE;
        runInstr("pc wrap", 0, 0, 0, 0, 0);

        PC = 16'h0100; SS = 8'h20; DS = 8'h30; ACC = 16'h1234;
        memOvr[int'(24'h201234)] = 8'hAB;
        memOvr[int'(24'h201235)] = 8'hCD;
        runInstr("load word SS", 1, 0, 1, 0, 0);
        checkOutput("load word literal", capMem, 16'hCDAB);

        PC = 16'h0200; ACC = 16'h5000;
        runInstr("ld+st byte", 1, 1, 0, 1, 0);
        checkOutput("ld+st byte upper zero", capMem[15:8], 8'h00);

        PC = 16'h0300; V2 = 16'hBEEF; ACC = 16'hFFFF;
        runInstr("store word wait3", 0, 1, 0, 0, 3);

        for (int i = 0; i < 30; i++) begin
            PC = 16'($urandom); CS = 8'($urandom); DS = 8'($urandom); SS = 8'($urandom);
            ACC = 16'($urandom); V2 = 16'($urandom);
            runInstr($sformatf("rand%0d", i), ($urandom_range(0, 2) == 0), 1'($urandom),
                     1'($urandom), 1'($urandom), $urandom_range(0, 2));
        end

        PC = 16'h4000; CS = 8'h12; ACC = 16'h0040;
        planLd = 0; planSt = 1; planSs = 0; planWb = 0; ackDelay = 6;
        clearObs();
        for (int t = 0; t < 200 && !sawWe; t++) applyStimulus(1'b1);
        checkOutput("midreset store reached", sawWe, 1'b1);
        resetDut();
        PC = 16'h4321;
        runInstr("after midreset", 0, 0, 0, 0, 0);
        checkOutput("release req", firstReq, 1'b1);
        checkOutput("release addr", firstAddr, {8'h12, 16'h4321});

`ifdef MEMU_BUS_TIMEOUT_EN
        resetDut();
        ackNever = 1;
        for (int t = 0; t < 300; t++) applyStimulus(1'b1);
        checkOutput("timeout fault tick", 48'(faultTick), 48'd257);
        checkOutput("timeout fault/req/busy", {bus_fault, bus_req, busy}, 3'b101);
        ackNever = 0;
        for (int t = 0; t < 20; t++) applyStimulus(1'b1);
        checkOutput("halt persists", {bus_fault, bus_req}, 2'b10);
        resetDut();
        runInstr("after halt", 0, 0, 0, 0, 0);
`else
        resetDut();
        ackNever = 1;
        for (int t = 0; t < 1000; t++) applyStimulus(1'b1);
        checkOutput("no fault ever", 48'(faultTick), 48'd0);
        checkOutput("still requesting", {bus_fault, bus_req}, 2'b01);
        checkOutput("still first addr", bus_addr, {CS, PC});
        ackNever = 0;
        runInstr("late ack", 0, 0, 0, 0, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
